alien_zigzag_ctrl: RTL and testbench

//  Generates the alien-block motion command stream consumed by the alien motion/collision block.

---
 rtl/alien_zigzag_ctrl.sv | 93 +++++++++
 tb/tb_alien_zigzag_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alien_zigzag_ctrl.sv
// Alien-block motion sequencer: paces zig-zag steps (right sweep, down, left sweep, down),
// shortens the step period on each kill and freezes on victory/defeat until reset.
module alien_zigzag_ctrl #(
    parameter int CNT_W       = 22,
    parameter int PERIOD_INIT = 2500000,
    parameter int PERIOD_MIN  = 250000,
    parameter int PERIOD_STEP = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       canLeft,
    input  logic       canRight,
    input  logic       killingAlien,
    input  logic       victory,
    input  logic       defeat,
    output logic [2:0] motion,
    output logic       dirRight,
    output logic       stopped
);

    localparam logic [2:0] LEFT  = 3'd1;
    localparam logic [2:0] RIGHT = 3'd2;
    localparam logic [2:0] DOWN  = 3'd3;

    typedef enum logic [1:0] {S_RIGHT, S_LEFT, S_STOP} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [2:0]       r_motion;
    logic             r_stopped;

    logic [CNT_W:0]   w_diff;
    logic [CNT_W-1:0] w_next_period;
    logic             w_step;

    // Extra bit keeps the subtraction from wrapping; the period<step term covers underflow.
    assign w_diff = {1'b0, r_period} - (CNT_W+1)'(PERIOD_STEP);
    assign w_next_period = ((r_period < CNT_W'(PERIOD_STEP)) ||
                            (w_diff < (CNT_W+1)'(PERIOD_MIN))) ? CNT_W'(PERIOD_MIN)
                                                               : w_diff[CNT_W-1:0];

    // >= rather than == so a period shortened below the running count fires at once.
    assign w_step = (r_cnt >= r_period - CNT_W'(1));

    // NOTE: all state here is updated with non-blocking assignments so every branch
    // sees the pre-edge values of r_cnt/r_period/r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RIGHT;
            r_cnt     <= '0;
            r_period  <= CNT_W'(PERIOD_INIT);
            r_motion  <= '0;
            r_stopped <= 1'b0;
        end else begin
            r_motion <= '0;
            if (r_state != S_STOP) begin
                if (victory || defeat) begin
                    r_state   <= S_STOP;
                    r_stopped <= 1'b1;
                end else begin
                    if (killingAlien)
                        r_period <= w_next_period;
                    if (w_step) begin
                        r_cnt <= '0;
                        if (r_state == S_RIGHT) begin
                            if (canRight) begin
                                r_motion <= RIGHT;
                            end else begin
                                r_motion <= DOWN;
                                r_state  <= S_LEFT;
                            end
                        end else begin
                            if (canLeft) begin
                                r_motion <= LEFT;
                            end else begin
                                r_motion <= DOWN;
                                r_state  <= S_RIGHT;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign motion   = r_motion;
    assign dirRight = (r_state == S_RIGHT);
    assign stopped  = r_stopped;

endmodule

// File: tb/tb_alien_zigzag_ctrl.sv
// Directed bench for alien_zigzag_ctrl with small periods (init 8, min 3, step 2).
module tb_alien_zigzag_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       canLeft, canRight, killingAlien, victory, defeat;
    logic [2:0] motion;
    logic       dirRight, stopped;

    int n_checks = 0;
    int n_fail   = 0;

    alien_zigzag_ctrl #(
        .CNT_W(4), .PERIOD_INIT(8), .PERIOD_MIN(3), .PERIOD_STEP(2)
    ) dut (
        .clk(clk), .reset(reset), .canLeft(canLeft), .canRight(canRight),
        .killingAlien(killingAlien), .victory(victory), .defeat(defeat),
        .motion(motion), .dirRight(dirRight), .stopped(stopped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Expect gap-1 idle cycles, then a pulse of the given code and direction.
    task automatic expect_pulse(input string tag, input int gap, input logic [2:0] code,
                                input logic dir);
        for (int i = 1; i <= gap; i++) begin
            cycle();
            if (i < gap) begin
                check({tag, "_idle"}, motion, 0);
            end else begin
                check({tag, "_code"}, motion, code);
                check({tag, "_dir"}, dirRight, dir);
            end
        end
    endtask

    initial begin
        int moved;
        reset = 1'b1; canLeft = 1'b1; canRight = 1'b1;
        killingAlien = 1'b0; victory = 1'b0; defeat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_motion", motion, 0);
        check("rst_dir", dirRight, 1);
        check("rst_stopped", stopped, 0);
        reset = 1'b0;

        // 1: rightward steps every 8 cycles
        expect_pulse("t1_step1", 8, 3'd2, 1'b1);
        expect_pulse("t1_step2", 8, 3'd2, 1'b1);

        // 2: right wall -> DOWN replaces third step, then left steps
        canRight = 1'b0;
        expect_pulse("t2_down", 8, 3'd3, 1'b0);
        canRight = 1'b1;
        expect_pulse("t2_left", 8, 3'd1, 1'b0);

        // 3: left wall -> DOWN, then right steps resume
        canLeft = 1'b0;
        expect_pulse("t3_down", 8, 3'd3, 1'b1);
        canLeft = 1'b1;
        expect_pulse("t3_right", 8, 3'd2, 1'b1);

        // 4: kill at cnt=6 with period 8 -> period 6, step on the next cycle
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("t4_pre_idle", motion, 0);
        end
        killingAlien = 1'b1;
        cycle();
        killingAlien = 1'b0;
        check("t4_kill_idle", motion, 0);
        cycle();
        check("t4_kill_step", motion, 2);
        expect_pulse("t4_p6", 6, 3'd2, 1'b1);
        // kill right after a step -> period 4
        killingAlien = 1'b1;
        cycle();
        killingAlien = 1'b0;
        check("t4_k2_idle", motion, 0);
        expect_pulse("t4_k2_step", 3, 3'd2, 1'b1);
        expect_pulse("t4_p4", 4, 3'd2, 1'b1);
        // two more kills: 4 -> 3 (floor), 3 -> 3 (floor)
        killingAlien = 1'b1;
        cycle();
        check("t4_k3_idle", motion, 0);
        cycle();
        killingAlien = 1'b0;
        check("t4_k4_idle", motion, 0);
        cycle();
        check("t4_k4_step", motion, 2);
        expect_pulse("t4_p3a", 3, 3'd2, 1'b1);
        expect_pulse("t4_p3b", 3, 3'd2, 1'b1);

        // 5: defeat on the step cycle suppresses the step and freezes
        cycle();
        check("t5_idle1", motion, 0);
        cycle();
        check("t5_idle2", motion, 0);
        defeat = 1'b1;
        cycle();
        defeat = 1'b0;
        check("t5_motion", motion, 0);
        check("t5_stopped", stopped, 1);
        check("t5_dir", dirRight, 0);
        moved = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (motion != 3'd0) moved++;
        end
        check("t5_frozen_pulses", moved, 0);
        check("t5_still_stopped", stopped, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t5_rst_stopped", stopped, 0);
        check("t5_rst_dir", dirRight, 1);
        expect_pulse("t5_resume", 8, 3'd2, 1'b1);

        // 6: both walls -> DOWN every step, direction toggles
        canLeft = 1'b0; canRight = 1'b0;
        expect_pulse("t6_down1", 8, 3'd3, 1'b0);
        expect_pulse("t6_down2", 8, 3'd3, 1'b1);
        expect_pulse("t6_down3", 8, 3'd3, 1'b0);

        // reset wins over a coincident victory
        canLeft = 1'b1; canRight = 1'b1;
        reset = 1'b1; victory = 1'b1;
        cycle();
        reset = 1'b0; victory = 1'b0;
        check("rv_stopped", stopped, 0);
        check("rv_dir", dirRight, 1);
        expect_pulse("rv_resume", 8, 3'd2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
